// File: rtl/led_colour_driver_pkg.sv
// Shared constants and types for the RGB LED colour driver.
package led_pkg;

  localparam int unsigned COL_R  = 0;
  localparam int unsigned COL_G  = 1;
  localparam int unsigned COL_B  = 2;
  localparam int unsigned NUM_CH = 3;

  typedef enum logic {
    STEADY = 1'b0,
    FADING = 1'b1
  } drv_state_t;

endpackage

// File: rtl/led_colour_driver_if.sv
// Colour-sequencer to LED-driver link: colour request in, pin drive and fade status out.
interface led_colour_driver_if #(
  parameter int unsigned PWM_BITS = 8
) ();
  import led_pkg::*;

  logic [NUM_CH-1:0]   colour;
  logic                enable;
  logic [PWM_BITS-1:0] brightness;
  logic                led_r;
  logic                led_g;
  logic                led_b;
  logic                busy;

  modport master (
    output colour, enable, brightness,
    input  led_r, led_g, led_b, busy
  );

  modport slave (
    input  colour, enable, brightness,
    output led_r, led_g, led_b, busy
  );

endinterface

// File: rtl/led_colour_driver_pwm_channel.sv
// One LED channel: duty register with saturating linear fade, and PWM compare.
module pwm_channel #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] tgt,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                enable,
  output logic                pin,
  output logic                settled
);

  logic [PWM_BITS-1:0] r_duty;
  logic                r_pin;
  logic [PWM_BITS-1:0] w_gap;
  logic [PWM_BITS-1:0] w_duty_nxt;

  // Step towards the target; a remaining gap within one step lands exactly on it.
  always_comb begin
    w_gap      = '0;
    w_duty_nxt = r_duty;
    if (r_duty < tgt) begin
      w_gap = tgt - r_duty;
      if (32'(w_gap) <= FADE_STEP) w_duty_nxt = tgt;
      else                         w_duty_nxt = r_duty + PWM_BITS'(FADE_STEP);
    end else if (r_duty > tgt) begin
      w_gap = r_duty - tgt;
      if (32'(w_gap) <= FADE_STEP) w_duty_nxt = tgt;
      else                         w_duty_nxt = r_duty - PWM_BITS'(FADE_STEP);
    end
  end

  // Duty only moves on the wrap so each PWM period uses a single duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
      r_pin  <= 1'b0;
    end else begin
      if (wrap) r_duty <= w_duty_nxt;
      r_pin <= enable & (cnt < r_duty);
    end
  end

  assign pin     = r_pin;
  assign settled = (r_duty == tgt);

endmodule

// File: rtl/led_colour_driver.sv
// RGB LED driver: colour decode, shared PWM counter, per-channel fade and busy FSM.
module led_colour_driver #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  led_colour_driver_if.slave bus
);
  import led_pkg::*;

  logic [PWM_BITS-1:0]               r_cnt;
  logic                              w_wrap;
  logic [NUM_CH-1:0][PWM_BITS-1:0]   w_tgt;
  logic [NUM_CH-1:0]                 w_pin;
  logic [NUM_CH-1:0]                 w_settled;
  drv_state_t                        r_state;
  drv_state_t                        w_state_nxt;

  // Free-running period counter shared by all channels.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + PWM_BITS'(1);
  end

  assign w_wrap = (r_cnt == '1);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    assign w_tgt[g] = bus.colour[g] ? bus.brightness : '0;

    pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wrap    (w_wrap),
      .tgt     (w_tgt[g]),
      .cnt     (r_cnt),
      .enable  (bus.enable),
      .pin     (w_pin[g]),
      .settled (w_settled[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= STEADY;
    else     r_state <= w_state_nxt;
  end

  // Settling is only judged on the cycle right after a wrap update (cnt back at 0).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      STEADY:  if (!(&w_settled)) w_state_nxt = FADING;
      FADING:  if ((r_cnt == '0) && (&w_settled)) w_state_nxt = STEADY;
      default: w_state_nxt = STEADY;
    endcase
  end

  assign bus.led_r = w_pin[COL_R];
  assign bus.led_g = w_pin[COL_G];
  assign bus.led_b = w_pin[COL_B];
  assign bus.busy  = (r_state == FADING);

endmodule

// File: tb/tb_led_colour_driver.sv
// Bench for led_colour_driver: cycle-level behavioural model plus directed period counts.
module tb_led_colour_driver;

  localparam int unsigned PWM_BITS  = 4;
  localparam int unsigned FADE_STEP = 4;
  localparam int          PERIOD    = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  led_colour_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_colour_driver #(
    .PWM_BITS  (PWM_BITS),
    .FADE_STEP (FADE_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer counter, per-channel duty, pins and busy flag.
  int m_cnt = 0;
  int m_duty [3] = '{0, 0, 0};
  bit m_led  [3] = '{0, 0, 0};
  bit m_busy = 1'b0;

  always @(posedge clk) begin
    int  tgt [3];
    bit  all_eq;
    for (int c = 0; c < 3; c++) tgt[c] = bus.colour[c] ? int'(bus.brightness) : 0;
    if (rst) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_led[c] = 1'b0; end
    end else begin
      all_eq = 1'b1;
      for (int c = 0; c < 3; c++) if (m_duty[c] != tgt[c]) all_eq = 1'b0;
      if (!m_busy) m_busy = !all_eq;
      else if (m_cnt == 0 && all_eq) m_busy = 1'b0;
      for (int c = 0; c < 3; c++) m_led[c] = bus.enable && (m_cnt < m_duty[c]);
      if (m_cnt == PERIOD - 1) begin
        for (int c = 0; c < 3; c++) begin
          if (m_duty[c] < tgt[c])
            m_duty[c] = (m_duty[c] + int'(FADE_STEP) > tgt[c]) ? tgt[c] : m_duty[c] + int'(FADE_STEP);
          else if (m_duty[c] > tgt[c])
            m_duty[c] = (m_duty[c] - int'(FADE_STEP) < tgt[c]) ? tgt[c] : m_duty[c] - int'(FADE_STEP);
        end
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT pins and busy against the model.
  always @(negedge clk) begin
    chk_bit("led_r", bus.led_r, m_led[0]);
    chk_bit("led_g", bus.led_g, m_led[1]);
    chk_bit("led_b", bus.led_b, m_led[2]);
    chk_bit("busy",  bus.busy,  m_busy);
  end

  // Counts high cycles of each pin over one whole PWM period (pins for cnt 0..15).
  task automatic count_period(output int hr, output int hg, output int hb);
    int guard = 0;
    hr = 0; hg = 0; hb = 0;
    while (m_cnt != 1 && guard < 40) begin @(negedge clk); guard++; end
    if (m_cnt != 1) begin
      chk_int("period_align", m_cnt, 1);
    end else begin
      for (int i = 0; i < PERIOD; i++) begin
        if (i > 0) @(negedge clk);
        hr += int'(bus.led_r);
        hg += int'(bus.led_g);
        hb += int'(bus.led_b);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    int guard = 0;
    while (m_cnt != v && guard < 40) begin @(negedge clk); guard++; end
    chk_int("wait_cnt", m_cnt, v);
  endtask

  initial begin
    int hr, hg, hb, hi;
    rst            = 1'b1;
    bus.colour     = 3'b001;
    bus.brightness = 4'd8;
    bus.enable     = 1'b1;

    // Reset and fade up on red
    repeat (3) begin
      @(negedge clk);
      chk_bit("rst_led_r", bus.led_r, 1'b0);
      chk_bit("rst_busy", bus.busy, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_bit("busy_after_release", bus.busy, 1'b1);
    count_period(hr, hg, hb); chk_int("fade_up_p1_r", hr, 0);
    count_period(hr, hg, hb); chk_int("fade_up_p2_r", hr, 4);
    count_period(hr, hg, hb); chk_int("fade_up_p3_r", hr, 8);
    chk_int("fade_up_p3_g", hg, 0);
    chk_int("fade_up_p3_b", hb, 0);
    chk_bit("busy_after_fade", bus.busy, 1'b0);
    chk_int("model_red_duty", m_duty[0], 8);

    // Reset mid-period with duty 8
    wait_cnt(3);
    chk_bit("pin_high_before_rst", bus.led_r, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_bit("midrst_led_r", bus.led_r, 1'b0);
    chk_bit("midrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_bit("midrst_busy_release", bus.busy, 1'b1);
    count_period(hr, hg, hb); chk_int("midrst_p1_r", hr, 0);

    // Retarget red -> green mid-fade
    do_reset();
    count_period(hr, hg, hb);
    repeat (5) @(negedge clk);
    chk_int("retarget_red_duty", m_duty[0], 4);
    bus.colour = 3'b010;
    count_period(hr, hg, hb);
    chk_int("retarget_p3_r", hr, 0);
    chk_int("retarget_p3_g", hg, 4);
    count_period(hr, hg, hb);
    chk_int("retarget_p4_g", hg, 8);

    // Saturation at brightness 6, white
    bus.colour     = 3'b111;
    bus.brightness = 4'd6;
    do_reset();
    count_period(hr, hg, hb);
    count_period(hr, hg, hb); chk_int("sat_p2_b", hb, 4);
    for (int p = 0; p < 2; p++) begin
      count_period(hr, hg, hb);
      chk_int("sat_r", hr, 6);
      chk_int("sat_g", hg, 6);
      chk_int("sat_b", hb, 6);
    end

    // enable low for 40 cycles during a blue fade to 15
    bus.colour     = 3'b100;
    bus.brightness = 4'd15;
    bus.enable     = 1'b0;
    do_reset();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hi += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
    end
    chk_int("disabled_pins_high", hi, 0);
    chk_int("duty_at_reenable", m_duty[2], 8);
    bus.enable = 1'b1;
    count_period(hr, hg, hb); chk_int("reenable_p4_b", hb, 12);
    count_period(hr, hg, hb); chk_int("reenable_p5_b", hb, 15);

    // Random traffic, including changes landing on the wrap cycle
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if (m_cnt == PERIOD - 1 && $urandom_range(0, 1) == 0)
        bus.colour = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) bus.colour = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) bus.brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
